// File: rtl/button_press_solver.sv
// Minimum button-press solver for the light/button wiring puzzle.
// Captures one line (target word followed by button masks), then walks all
// button subsets in Gray-code order to find the smallest subset whose XOR
// equals the target. The per-line minima are summed into result.
//
// state    | meaning
// S_IDLE   | waiting for a completed line to hand off
// S_SEARCH | one Gray-code subset per cycle, tracking best press count
// S_ACCUM  | fold best into result, or flag the line as unsolvable
module button_press_solver #(
  parameter int MAX_WIRING_WIDTH = 16,
  parameter int MAX_BUTTONS      = 13,
  parameter int RESULT_WIDTH     = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        end_of_file,
  input  logic                        end_of_line,
  input  logic                        wiring_valid,
  input  logic [MAX_WIRING_WIDTH-1:0] wiring_data,
  output logic                        busy,
  output logic                        result_valid,
  output logic [RESULT_WIDTH-1:0]     result,
  output logic                        err_overrun,
  output logic                        err_too_many_buttons,
  output logic                        err_unsolvable
);

  localparam int CNT_W = $clog2(MAX_BUTTONS + 1);
  // One spare bit so the all-ones "no solution" marker can never equal a real count.
  localparam int POP_W = CNT_W + 1;
  // k never exceeds 2^n-1, so MAX_BUTTONS bits suffice; the last-subset
  // compare relies on 1<<MAX_BUTTONS wrapping to zero at this width.
  localparam int K_W   = MAX_BUTTONS;
  localparam int IDX_W = (MAX_BUTTONS > 1) ? $clog2(MAX_BUTTONS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_SEARCH, S_ACCUM} state_t;

  // capture buffer
  logic [MAX_WIRING_WIDTH-1:0] r_cap_target;
  logic                        r_cap_has_target;
  logic [MAX_WIRING_WIDTH-1:0] r_cap_buttons [MAX_BUTTONS];
  logic [CNT_W-1:0]            r_cap_count;

  // solver
  state_t                      r_state;
  state_t                      w_state_next;
  logic [MAX_WIRING_WIDTH-1:0] r_target;
  logic [MAX_WIRING_WIDTH-1:0] r_masks [MAX_BUTTONS];
  logic [CNT_W-1:0]            r_n;
  logic [K_W-1:0]              r_k;
  logic [MAX_BUTTONS-1:0]      r_gray;
  logic [MAX_WIRING_WIDTH-1:0] r_acc;
  logic [POP_W-1:0]            r_pop;
  logic [POP_W-1:0]            r_best;

  logic [RESULT_WIDTH-1:0]     r_result;
  logic                        r_result_valid;
  logic                        r_err_overrun;
  logic                        r_err_too_many;
  logic                        r_err_unsolvable;
  logic                        r_eof_d;

  logic [MAX_WIRING_WIDTH-1:0] w_line_target;
  logic                        w_line_has_target;
  logic [CNT_W-1:0]            w_line_count;
  logic                        w_append;
  logic                        w_drop;
  logic                        w_line_evt;
  logic                        w_handoff;
  logic                        w_overrun;
  logic [K_W-1:0]              w_k_next;
  logic [IDX_W-1:0]            w_idx;
  logic                        w_k_last;
  logic [MAX_BUTTONS-1:0]      w_bit_sel;
  logic [MAX_BUTTONS-1:0]      w_gray_next;
  logic                        w_bit_set;

  // Line as it stands after this cycle's word, so a word coinciding with LF
  // is part of the handed-off line.
  always_comb begin
    w_line_target     = r_cap_target;
    w_line_has_target = r_cap_has_target;
    w_line_count      = r_cap_count;
    w_append          = 1'b0;
    w_drop            = 1'b0;
    if (wiring_valid && !r_result_valid) begin
      if (!r_cap_has_target) begin
        w_line_target     = wiring_data;
        w_line_has_target = 1'b1;
      end else if (r_cap_count < CNT_W'(MAX_BUTTONS)) begin
        w_append     = 1'b1;
        w_line_count = r_cap_count + CNT_W'(1);
      end else begin
        w_drop = 1'b1;
      end
    end
  end

  // End of file acts as a final LF on its first high cycle only.
  assign w_line_evt = (end_of_line | (end_of_file & ~r_eof_d)) & w_line_has_target & ~r_result_valid;
  assign w_handoff  = w_line_evt & (r_state == S_IDLE);
  assign w_overrun  = w_line_evt & (r_state != S_IDLE);

  // Gray-code step: trailing-zero count of k+1 selects the button to toggle.
  always_comb begin
    w_k_next = r_k + K_W'(1);
    w_idx    = '0;
    for (int i = MAX_BUTTONS - 1; i >= 0; i--) begin
      if (w_k_next[i]) w_idx = IDX_W'(i);
    end
    w_k_last    = (r_k == ((K_W'(1) << r_n) - K_W'(1)));
    w_bit_sel   = MAX_BUTTONS'(1) << w_idx;
    w_gray_next = r_gray ^ w_bit_sel;
    w_bit_set   = |(w_gray_next & w_bit_sel);
  end

  // Capture buffer: load target, append buttons, clear on line completion.
  always_ff @(posedge clk) begin
    if (rst || w_line_evt) begin
      r_cap_target     <= '0;
      r_cap_has_target <= 1'b0;
      r_cap_count      <= '0;
      for (int i = 0; i < MAX_BUTTONS; i++) r_cap_buttons[i] <= '0;
    end else begin
      r_cap_target     <= w_line_target;
      r_cap_has_target <= w_line_has_target;
      r_cap_count      <= w_line_count;
      for (int i = 0; i < MAX_BUTTONS; i++) begin
        if (w_append && (r_cap_count == CNT_W'(i))) r_cap_buttons[i] <= wiring_data;
      end
    end
  end

  // Solver state register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  // Solver next-state logic.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:   if (w_handoff) w_state_next = S_SEARCH;
      S_SEARCH: if (w_k_last)  w_state_next = S_ACCUM;
      S_ACCUM:  w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
  end

  // Solver datapath, accumulation, sticky errors and completion flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_target         <= '0;
      r_n              <= '0;
      r_k              <= '0;
      r_gray           <= '0;
      r_acc            <= '0;
      r_pop            <= '0;
      r_best           <= '1;
      r_result         <= '0;
      r_result_valid   <= 1'b0;
      r_err_overrun    <= 1'b0;
      r_err_too_many   <= 1'b0;
      r_err_unsolvable <= 1'b0;
      r_eof_d          <= 1'b0;
      for (int i = 0; i < MAX_BUTTONS; i++) r_masks[i] <= '0;
    end else begin
      r_eof_d <= end_of_file;
      if (w_overrun) r_err_overrun  <= 1'b1;
      if (w_drop)    r_err_too_many <= 1'b1;

      if (w_handoff) begin
        r_target <= w_line_target;
        r_n      <= w_line_count;
        r_k      <= '0;
        r_gray   <= '0;
        r_acc    <= '0;
        r_pop    <= '0;
        r_best   <= '1;
        for (int i = 0; i < MAX_BUTTONS; i++) begin
          r_masks[i] <= (w_append && (r_cap_count == CNT_W'(i))) ? wiring_data : r_cap_buttons[i];
        end
      end

      if (r_state == S_SEARCH) begin
        if ((r_acc == r_target) && (r_pop < r_best)) r_best <= r_pop;
        if (!w_k_last) begin
          r_k    <= w_k_next;
          r_gray <= w_gray_next;
          r_acc  <= r_acc ^ r_masks[w_idx];
          r_pop  <= w_bit_set ? (r_pop + POP_W'(1)) : (r_pop - POP_W'(1));
        end
      end

      if (r_state == S_ACCUM) begin
        if (r_best != '1) r_result <= r_result + RESULT_WIDTH'(r_best);
        else              r_err_unsolvable <= 1'b1;
      end

      if (end_of_file && !w_line_has_target && (r_state == S_IDLE)) r_result_valid <= 1'b1;
    end
  end

  assign busy                 = (r_state != S_IDLE);
  assign result_valid         = r_result_valid;
  assign result               = r_result;
  assign err_overrun          = r_err_overrun;
  assign err_too_many_buttons = r_err_too_many;
  assign err_unsolvable       = r_err_unsolvable;

endmodule

// File: tb/tb_button_press_solver.sv
// Directed bench for button_press_solver: lines are driven word by word,
// the expected minimum press count of each line comes from a brute-force
// subset model and is queued, then popped when the solver drops busy.
module tb_button_press_solver;

  logic        clk = 1'b0;
  logic        rst;
  logic        end_of_file;
  logic        end_of_line;
  logic        wiring_valid;
  logic [15:0] wiring_data;
  logic        busy;
  logic        result_valid;
  logic [31:0] result;
  logic        err_overrun;
  logic        err_too_many_buttons;
  logic        err_unsolvable;

  always #5 clk = ~clk;

  button_press_solver #(
    .MAX_WIRING_WIDTH(16),
    .MAX_BUTTONS(13),
    .RESULT_WIDTH(32)
  ) dut (
    .clk(clk),
    .rst(rst),
    .end_of_file(end_of_file),
    .end_of_line(end_of_line),
    .wiring_valid(wiring_valid),
    .wiring_data(wiring_data),
    .busy(busy),
    .result_valid(result_valid),
    .result(result),
    .err_overrun(err_overrun),
    .err_too_many_buttons(err_too_many_buttons),
    .err_unsolvable(err_unsolvable)
  );

  typedef struct {
    int presses;
    bit solvable;
    int n;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] btn [16];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          n_fail   = 0;
  logic [31:0] exp_result;
  logic        exp_unsolv;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Brute force over every subset of the stored buttons; -1 when unreachable.
  function automatic int model(input logic [15:0] tgt, input int n);
    int m;
    int best;
    logic [15:0] acc;
    m = (n > 13) ? 13 : n;
    best = -1;
    for (int s = 0; s < (1 << m); s++) begin
      acc = '0;
      for (int i = 0; i < m; i++) if (s[i]) acc ^= btn[i];
      if (acc == tgt && (best < 0 || $countones(s) < best)) best = $countones(s);
    end
    return best;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    end_of_file = 1'b0;
    end_of_line = 1'b0;
    wiring_valid = 1'b0;
    wiring_data = '0;
    tick();
    tick();
    rst = 1'b0;
    exp_result = '0;
    exp_unsolv = 1'b0;
    sb.delete();
  endtask

  task automatic send_line(input logic [15:0] tgt, input int n, input bit coincide,
                           input bit lf, input bit push);
    int p;
    wiring_valid = 1'b1;
    wiring_data = tgt;
    tick();
    for (int i = 0; i < n; i++) begin
      wiring_data = btn[i];
      if (coincide && lf && i == n - 1) end_of_line = 1'b1;
      tick();
    end
    wiring_valid = 1'b0;
    if (lf && !(coincide && n > 0)) begin
      end_of_line = 1'b1;
      tick();
    end
    end_of_line = 1'b0;
    if (push) begin
      p = model(tgt, n);
      sb.push_back('{p, (p >= 0), ((n > 13) ? 13 : n)});
    end
  endtask

  task automatic wait_solve(input bit chk_dur);
    int dur;
    int guard;
    exp_t e;
    dur = 0;
    guard = 0;
    while (!busy && guard < 100) begin
      tick();
      guard++;
    end
    check("busy_rise", busy, 1);
    while (busy && dur < 20000) begin
      tick();
      dur++;
    end
    check("busy_fall", busy, 0);
    check("sb_nonempty", (sb.size() != 0), 1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      if (chk_dur) check("busy_cycles", dur, (1 << e.n) + 1);
      if (e.solvable) exp_result = exp_result + e.presses;
      else exp_unsolv = 1'b1;
      check("result", result, exp_result);
      check("err_unsolvable", err_unsolvable, exp_unsolv);
    end
  endtask

  task automatic wait_rv();
    int guard;
    guard = 0;
    while (!result_valid && guard < 50) begin
      tick();
      guard++;
    end
    check("result_valid", result_valid, 1);
  endtask

  initial begin
    // reset values
    do_reset();
    check("rst_busy", busy, 0);
    check("rst_result_valid", result_valid, 0);
    check("rst_result", result, 0);
    check("rst_err_overrun", err_overrun, 0);
    check("rst_err_too_many", err_too_many_buttons, 0);
    check("rst_err_unsolvable", err_unsolvable, 0);

    // three-line example; line 1 is the 65-cycle search
    btn[0] = 16'h8; btn[1] = 16'hA; btn[2] = 16'h4;
    btn[3] = 16'hC; btn[4] = 16'h5; btn[5] = 16'h3;
    send_line(16'h6, 6, 1'b0, 1'b1, 1'b1);
    wait_solve(1'b1);
    check("line1_result", result, 2);
    btn[0] = 16'h1D; btn[1] = 16'hC; btn[2] = 16'h11; btn[3] = 16'h7; btn[4] = 16'h1E;
    send_line(16'h8, 5, 1'b0, 1'b1, 1'b1);
    wait_solve(1'b1);
    // last button arrives in the same cycle as LF
    btn[0] = 16'h1F; btn[1] = 16'h19; btn[2] = 16'h37; btn[3] = 16'h6;
    send_line(16'h2E, 4, 1'b1, 1'b1, 1'b1);
    wait_solve(1'b1);
    end_of_file = 1'b1;
    wait_rv();
    check("puzzle_result", result, 7);
    check("puzzle_err_overrun", err_overrun, 0);
    check("puzzle_err_too_many", err_too_many_buttons, 0);
    check("puzzle_err_unsolvable", err_unsolvable, 0);
    for (int i = 0; i < 4; i++) tick();
    check("frozen_result", result, 7);
    check("frozen_valid", result_valid, 1);

    // unsolvable line
    do_reset();
    btn[0] = 16'h2;
    send_line(16'h1, 1, 1'b0, 1'b1, 1'b1);
    wait_solve(1'b1);
    check("unsolv_flag", err_unsolvable, 1);
    check("unsolv_result", result, 0);
    check("unsolv_no_overrun", err_overrun, 0);

    // 14 buttons (last dropped, it alone would hit the target), then a line during the search
    do_reset();
    for (int i = 0; i < 13; i++) btn[i] = 16'(1 << i);
    btn[13] = 16'h7;
    send_line(16'h7, 14, 1'b0, 1'b1, 1'b1);
    btn[0] = 16'h1;
    send_line(16'h1, 1, 1'b0, 1'b1, 1'b0);
    check("ovr_err_overrun", err_overrun, 1);
    check("ovr_err_too_many", err_too_many_buttons, 1);
    wait_solve(1'b0);
    check("ovr_result", result, 3);
    for (int i = 0; i < 3; i++) tick();
    check("ovr_no_second_search", busy, 0);

    // target 0 with no buttons
    do_reset();
    send_line(16'h0, 0, 1'b0, 1'b1, 1'b1);
    wait_solve(1'b1);
    end_of_file = 1'b1;
    wait_rv();
    check("zero_result", result, 0);

    // reset during a search, then a line terminated by end of file
    do_reset();
    btn[0] = 16'h8; btn[1] = 16'hA; btn[2] = 16'h4;
    btn[3] = 16'hC; btn[4] = 16'h5; btn[5] = 16'h3;
    send_line(16'h6, 6, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) tick();
    check("mid_busy", busy, 1);
    do_reset();
    check("post_rst_busy", busy, 0);
    check("post_rst_result", result, 0);
    btn[0] = 16'h3;
    send_line(16'h3, 1, 1'b0, 1'b0, 1'b1);
    end_of_file = 1'b1;
    wait_solve(1'b1);
    wait_rv();
    check("rst_line_result", result, 1);
    check("rst_line_overrun", err_overrun, 0);
    check("rst_line_too_many", err_too_many_buttons, 0);
    check("rst_line_unsolvable", err_unsolvable, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
